// File: rtl/dct_pkg.sv
// Shared constants for the 2D DCT pipeline: transform size, coefficient width
// and the Q3.12 fractional-bit position used by the 1D stages.
package dct_pkg;
   localparam int DCT_N          = 8;
   localparam int DCT_DATA_WIDTH = 16;
   localparam int DCT_FRAC_BITS  = 12;

   // Counter width for an index in 0..n-1; never zero so n == 1 still elaborates.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/transpose_bank.sv
// One N x N coefficient block: whole-row write port, whole-column combinational read.
module transpose_bank
   import dct_pkg::*;
#(
   parameter int N          = DCT_N,
   parameter int DATA_WIDTH = DCT_DATA_WIDTH,
   parameter int RW         = idx_width(N)
) (
   input  logic                    clk,
   input  logic                    wr_en_i,
   input  logic [RW-1:0]           wr_row_i,
   input  logic [N*DATA_WIDTH-1:0] row_i,
   input  logic [RW-1:0]           rd_col_i,
   output logic [N*DATA_WIDTH-1:0] col_o
);
   // Data is intentionally not reset; the full flags in the parent gate validity.
   logic [N-1:0][N*DATA_WIDTH-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_row_i] <= row_i;
   end

   always_comb begin
      col_o = '0;
      for (int r = 0; r < N; r++)
         col_o[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][rd_col_i*DATA_WIDTH +: DATA_WIDTH];
   end
endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer between row and column 1D DCT stages:
// rows go into one bank while columns stream out of the other.
module dct_transpose_buffer
   import dct_pkg::*;
#(
   parameter int N          = DCT_N,
   parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_row,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N*DATA_WIDTH-1:0] out_col,
   output logic                    out_last
);
   localparam int RW = idx_width(N);
   localparam logic [RW-1:0] LAST_IDX = RW'(N-1);

   logic [1:0]    full_q, full_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [RW-1:0] wr_row_q, wr_row_d;
   logic [RW-1:0] rd_col_q, rd_col_d;

   logic          accept, handshake;
   logic [1:0]    bank_we;
   logic [1:0][N*DATA_WIDTH-1:0] bank_col;

   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign out_col   = bank_col[rd_bank_q];
   assign out_last  = out_valid && (rd_col_q == LAST_IDX);

   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;

   // Both banks see the same read column; only the read bank's result is muxed out.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign bank_we[b] = accept && (wr_bank_q == b[0]);

      transpose_bank #(
         .N          (N),
         .DATA_WIDTH (DATA_WIDTH),
         .RW         (RW)
      ) u_bank (
         .clk      (clk),
         .wr_en_i  (bank_we[b]),
         .wr_row_i (wr_row_q),
         .row_i    (in_row),
         .rd_col_i (rd_col_q),
         .col_o    (bank_col[b])
      );
   end

   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_row_d  = wr_row_q;
      rd_col_d  = rd_col_q;

      if (accept) begin
         if (wr_row_q == LAST_IDX) begin
            wr_row_d          = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end else begin
            wr_row_d = wr_row_q + 1'b1;
         end
      end

      // A completing write and a completing read always hit different banks,
      // so both flag updates can be applied independently.
      if (handshake) begin
         if (rd_col_q == LAST_IDX) begin
            rd_col_d          = '0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end else begin
            rd_col_d = rd_col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_col_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_row_q  <= wr_row_d;
         rd_col_q  <= rd_col_d;
      end
   end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench: accepted blocks are transposed by the bench model into a
// queue of expected columns, compared as the buffer presents them.
module tb_dct_transpose_buffer;
   localparam int N  = 8;
   localparam int DW = 16;
   localparam int W  = N*DW;

   logic         clk, rst;
   logic         in_valid, in_ready;
   logic [W-1:0] in_row;
   logic         out_valid, out_ready, out_last;
   logic [W-1:0] out_col;

   dct_transpose_buffer #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Model state
   logic [W-1:0] exp_q[$];
   logic [W-1:0] blk [N];
   int nfull = 0, wrow = 0, rcol = 0;
   int hs_cnt = 0, rdy_low_cnt = 0;
   int or_mode = 0;  // 0: always ready, 1: never ready, 2: toggle

   always @(negedge clk) begin
      logic exp_rdy, exp_ov, acc, hs;
      logic [W-1:0] col;
      if (rst) begin
         chk("rst_in_ready", W'(in_ready), W'(1));
         chk("rst_out_valid", W'(out_valid), W'(0));
         chk("rst_out_last", W'(out_last), W'(0));
         exp_q.delete();
         nfull = 0; wrow = 0; rcol = 0;
      end else begin
         exp_rdy = (nfull < 2);
         exp_ov  = (nfull > 0);
         chk("in_ready", W'(in_ready), W'(exp_rdy));
         chk("out_valid", W'(out_valid), W'(exp_ov));
         if (!in_ready) rdy_low_cnt++;
         if (exp_ov) begin
            chk("out_col", out_col, exp_q[0]);
            chk("out_last", W'(out_last), W'(rcol == N-1));
         end else begin
            chk("out_last_idle", W'(out_last), W'(0));
         end
         acc = in_valid && exp_rdy;
         hs  = exp_ov && out_ready;
         if (hs) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            rcol++;
            if (rcol == N) begin rcol = 0; nfull--; end
         end
         if (acc) begin
            blk[wrow] = in_row;
            wrow++;
            if (wrow == N) begin
               wrow = 0;
               nfull++;
               for (int c = 0; c < N; c++) begin
                  col = '0;
                  for (int r = 0; r < N; r++) col[r*DW +: DW] = blk[r][c*DW +: DW];
                  exp_q.push_back(col);
               end
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ~out_ready;
         endcase
      end
   end

   function automatic logic [W-1:0] seq_row(input int base, input int r);
      logic [W-1:0] v;
      for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'(base + r*8 + c);
      return v;
   endfunction

   function automatic logic [W-1:0] rnd_row();
      logic [W-1:0] v;
      for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   function automatic logic [W-1:0] ext_row(input int r);
      logic [W-1:0] v;
      for (int c = 0; c < N; c++)
         case ((r*3 + c) % 3)
            0:       v[c*DW +: DW] = 16'h8000;
            1:       v[c*DW +: DW] = 16'h7FFF;
            default: v[c*DW +: DW] = DW'(r*16 + c);
         endcase
      return v;
   endfunction

   // Offer a row and hold it until the buffer takes it.
   task automatic put_row(input logic [W-1:0] row);
      int  t;
      logic r;
      in_valid = 1'b1;
      in_row   = row;
      t = 0;
      forever begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk); #1;
         if (r) break;
         t++;
         if (t > 300) begin chk("put_timeout", W'(0), W'(1)); break; end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0 && nfull == 0) return;
         @(posedge clk); #1;
      end
      chk("drain_timeout", W'(exp_q.size()), W'(0));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_row = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Basic transpose, element[r][c] = r*8+c
      or_mode = 0; hs_cnt = 0;
      for (int r = 0; r < N; r++) put_row(seq_row(0, r));
      wait_empty();
      chk("basic_cols", W'(hs_cnt), W'(N));

      // Three back-to-back blocks
      hs_cnt = 0; rdy_low_cnt = 0;
      for (int b = 0; b < 3; b++)
         for (int r = 0; r < N; r++) put_row((b == 1) ? seq_row(64, r) : rnd_row());
      wait_empty();
      chk("b2b_cols", W'(hs_cnt), W'(3*N));
      chk("b2b_ready_drops", W'(rdy_low_cnt), W'(0));

      // Backpressure: fill both banks, 17th row must be refused
      or_mode = 1; hs_cnt = 0;
      @(posedge clk); #1;
      for (int r = 0; r < 2*N; r++) put_row(seq_row(r < N ? 128 : 192, r % N));
      in_valid = 1'b1; in_row = {W{1'b1}};
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_out_valid", W'(out_valid), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      or_mode = 0;
      wait_empty();
      chk("bp_cols", W'(hs_cnt), W'(2*N));

      // Stall stability with out_ready toggling
      or_mode = 2; hs_cnt = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < N; r++) put_row(rnd_row());
      wait_empty();
      chk("stall_cols", W'(hs_cnt), W'(2*N));

      // Signed extremes
      or_mode = 0; hs_cnt = 0;
      for (int r = 0; r < N; r++) put_row(ext_row(r));
      wait_empty();
      chk("ext_cols", W'(hs_cnt), W'(N));

      // Reset mid-block after 3 rows
      for (int r = 0; r < 3; r++) put_row(rnd_row());
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", W'(in_ready), W'(1));
      chk("midrst_out_valid", W'(out_valid), W'(0));
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      hs_cnt = 0;
      for (int r = 0; r < N; r++) put_row(seq_row(300, r));
      wait_empty();
      chk("midrst_cols", W'(hs_cnt), W'(N));

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
